// File: rtl/prog_timer_if.sv
// Bus bundle between the timer and its controller.
// The prescale field exists only when TIMER_PRESCALE_EN is defined.
interface prog_timer_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
);
  logic             start;
  logic             stop;
  logic             periodic;
  logic [WIDTH-1:0] load_value;
`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  // Controller side: issues commands, observes timer status.
  modport master (
    output start, stop, periodic, load_value,
`ifdef TIMER_PRESCALE_EN
    output prescale,
`endif
    input  count, busy, done
  );

  // Timer side: consumes commands, reports status.
  modport slave (
    input  start, stop, periodic, load_value,
`ifdef TIMER_PRESCALE_EN
    input  prescale,
`endif
    output count, busy, done
  );
endinterface

// File: rtl/prog_timer.sv
// Programmable down-counting timer with one-shot / periodic auto-reload,
// stop/abort and restart-on-start. done pulses for one cycle on each expiry.
// Optional clock prescaler enabled by defining TIMER_PRESCALE_EN; without it
// the timer ticks every clock.
module prog_timer #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  prog_timer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  // Tick on the last clock of each prescale window.
  assign tick = (pcnt_q == psc_q);
`else
  assign tick = 1'b1;
`endif

  // Next-state and datapath: priority stop > start > tick/expiry.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
`ifdef TIMER_PRESCALE_EN
    pcnt_d   = pcnt_q;
    psc_d    = psc_q;
`endif
    case (state_q)
      IDLE: begin
        // stop outranks start even here; alone it changes nothing in IDLE.
        if (bus.start && !bus.stop) begin
          state_d  = RUN;
          count_d  = bus.load_value;
          reload_d = bus.load_value;
          mode_d   = bus.periodic;
`ifdef TIMER_PRESCALE_EN
          pcnt_d   = '0;
          psc_d    = bus.prescale;
`endif
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          count_d = '0;
`ifdef TIMER_PRESCALE_EN
          pcnt_d  = '0;
`endif
        end else if (bus.start) begin
          // Restart swallows any expiry due this cycle.
          count_d  = bus.load_value;
          reload_d = bus.load_value;
          mode_d   = bus.periodic;
`ifdef TIMER_PRESCALE_EN
          pcnt_d   = '0;
          psc_d    = bus.prescale;
`endif
        end else if (tick) begin
`ifdef TIMER_PRESCALE_EN
          pcnt_d = '0;
`endif
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else begin
            done_d = 1'b1;
            if (mode_q) begin
              count_d = reload_q;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
`ifdef TIMER_PRESCALE_EN
          pcnt_d = pcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      pcnt_q   <= '0;
      psc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
`ifdef TIMER_PRESCALE_EN
      pcnt_q   <= pcnt_d;
      psc_q    <= psc_d;
`endif
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer. Expected expiry cycles are queued when
// a start is driven; a negedge monitor pops and compares on every done pulse.
// Build with TIMER_PRESCALE_EN defined to include the prescaler scenario.
module tb_prog_timer;
  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;

  logic clk = 1'b0;
  logic rst;

  prog_timer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  prog_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Scoreboard: every done pulse must match the oldest expected expiry cycle.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          errors++;
          $display("FAIL done_cycle: got %0d want %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // One cycle of start; optionally queue the expected expiry cycle.
  task automatic drive_start(input int n, input bit per, input int psc, input bit push);
    bus.start      = 1'b1;
    bus.load_value = n[WIDTH-1:0];
    bus.periodic   = per;
`ifdef TIMER_PRESCALE_EN
    bus.prescale   = psc[PRESCALE_W-1:0];
`endif
    if (push) exp_q.push_back(cyc + 1 + (n + 1) * (psc + 1));
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.periodic = 1'b0; bus.load_value = '0;
`ifdef TIMER_PRESCALE_EN
    bus.prescale = '0;
`endif
    step(3);
    checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.count !== 16'd0) begin errors++; $display("FAIL idle_stop: got busy=%b count=%0d want 0/0", bus.busy, bus.count); end
  endtask

  task automatic test_one_shot();
    drive_start(5, 1'b0, 0, 1'b1);
    checks++; if (bus.count !== 16'd5 || bus.busy !== 1'b1) begin errors++; $display("FAIL oneshot_load: got count=%0d busy=%b want 5/1", bus.count, bus.busy); end
    for (int i = 4; i >= 0; i--) begin
      step(1);
      checks++; if (bus.count !== i || bus.busy !== 1'b1) begin errors++; $display("FAIL oneshot_count: got count=%0d busy=%b want %0d/1", bus.count, bus.busy, i); end
    end
    step(1);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 16'd0) begin errors++; $display("FAIL oneshot_expire: got done=%b busy=%b count=%0d want 1/0/0", bus.done, bus.busy, bus.count); end
    step(1);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL oneshot_pulse_width: got done=%b want 0", bus.done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL oneshot_missed: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_periodic();
    for (int k = 1; k <= 5; k++) exp_q.push_back(cyc + 1 + 4 * k);
    drive_start(3, 1'b1, 0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      checks++; if (bus.busy !== 1'b1 || bus.count !== (3 - (k % 4))) begin errors++; $display("FAIL periodic_run: got busy=%b count=%0d want 1/%0d", bus.busy, bus.count, 3 - (k % 4)); end
    end
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.count !== 16'd0) begin errors++; $display("FAIL periodic_stop: got busy=%b count=%0d want 0/0", bus.busy, bus.count); end
    step(5);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL periodic_missed: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_abort();
    drive_start(10, 1'b0, 0, 1'b0);
    step(6);
    checks++; if (bus.count !== 16'd4) begin errors++; $display("FAIL abort_pre: got %0d want 4", bus.count); end
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.count !== 16'd0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_mid: got busy=%b count=%0d done=%b want 0/0/0", bus.busy, bus.count, bus.done); end
    step(12);
    drive_start(2, 1'b0, 0, 1'b0);
    step(2);
    checks++; if (bus.count !== 16'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL abort_zero_pre: got count=%0d busy=%b want 0/1", bus.count, bus.busy); end
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL abort_at_expiry: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    step(3);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_queue: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_restart();
    drive_start(8, 1'b0, 0, 1'b0);
    step(5);
    checks++; if (bus.count !== 16'd3) begin errors++; $display("FAIL restart_pre: got %0d want 3", bus.count); end
    drive_start(2, 1'b0, 0, 1'b1);
    checks++; if (bus.count !== 16'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL restart_load: got count=%0d busy=%b want 2/1", bus.count, bus.busy); end
    step(2);
    checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL restart_count: got %0d want 0", bus.count); end
    step(1);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL restart_done: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
    step(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL restart_missed: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_zero();
    drive_start(0, 1'b0, 0, 1'b1);
    checks++; if (bus.count !== 16'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL zero_load: got count=%0d busy=%b want 0/1", bus.count, bus.busy); end
    step(1);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_oneshot: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
    step(2);
    for (int k = 1; k <= 6; k++) exp_q.push_back(cyc + 1 + k);
    drive_start(0, 1'b1, 0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL zero_periodic: got done=%b busy=%b want 1/1", bus.done, bus.busy); end
    end
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero_stop: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
    step(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL zero_missed: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'b1; bus.load_value = 16'd1; bus.periodic = 1'b0;
      step(1);
      checks++; if (bus.count !== 16'd1 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_hold: got count=%0d busy=%b want 1/1", bus.count, bus.busy); end
    end
    drive_start(1, 1'b0, 0, 1'b1);
    step(1);
    checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL b2b_count: got %0d want 0", bus.count); end
    step(1);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", bus.done); end
    step(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missed: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_max();
    drive_start(65535, 1'b0, 0, 1'b1);
    checks++; if (bus.count !== 16'hFFFF) begin errors++; $display("FAIL max_load: got %0h want ffff", bus.count); end
    step(65535);
    checks++; if (bus.count !== 16'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL max_count: got count=%0d busy=%b want 0/1", bus.count, bus.busy); end
    step(1);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 16'd0) begin errors++; $display("FAIL max_expire: got done=%b busy=%b count=%0d want 1/0/0", bus.done, bus.busy, bus.count); end
    step(1);
    checks++; if (bus.count !== 16'd0) begin errors++; $display("FAIL max_nowrap: got %0d want 0", bus.count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL max_missed: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_run();
    drive_start(20, 1'b1, 0, 1'b0);
    step(5);
    rst = 1'b1;
    step(1);
    checks++; if (bus.count !== 16'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid: got count=%0d busy=%b done=%b want 0/0/0", bus.count, bus.busy, bus.done); end
    rst = 1'b0;
    step(3);
    checks++; if (bus.busy !== 1'b0 || bus.count !== 16'd0) begin errors++; $display("FAIL rst_after: got busy=%b count=%0d want 0/0", bus.busy, bus.count); end
    exp_q.delete();
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    drive_start(2, 1'b0, 3, 1'b1);
    checks++; if (bus.count !== 16'd2) begin errors++; $display("FAIL psc_load: got %0d want 2", bus.count); end
    for (int k = 1; k <= 11; k++) begin
      step(1);
      checks++; if (bus.count !== (2 - k / 4) || bus.busy !== 1'b1) begin errors++; $display("FAIL psc_count: got count=%0d busy=%b want %0d/1", bus.count, bus.busy, 2 - k / 4); end
    end
    step(1);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL psc_done: got done=%b busy=%b want 1/0", bus.done, bus.busy); end
    step(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL psc_missed: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_abort();
    test_restart();
    test_zero();
    test_back_to_back();
    test_reset_mid_run();
`ifdef TIMER_PRESCALE_EN
    test_prescale();
`endif
    test_max();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
